// File: rtl/scr1_btb_pkg.sv
// Shared types, sizes and PC field extraction for the SCR1 branch target buffer.
package scr1_btb_pkg;

    localparam int unsigned BTB_DEPTH = 32;
    localparam int unsigned IDX_W     = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W     = 31 - IDX_W;
    localparam int unsigned ENTRY_W   = 1 + TAG_W + 31;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } type_scr1_btb_state_e;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [30:0]      target;
    } type_scr1_btb_entry_s;

    // PC split into the stored tag and the RAM index
    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } type_scr1_btb_pc_s;

    // tag = {pc[31:IDX_W+2], pc[1]}, idx = pc[IDX_W+1:2]; pc[0] never matters
    function automatic type_scr1_btb_pc_s btb_pc_split(input logic [31:1] pc);
        btb_pc_split = {pc[31:IDX_W+2], pc[1], pc[IDX_W+1:2]};
    endfunction

endpackage

// File: rtl/scr1_btb_ctrl_if.sv
// IFU lookup, EXU update and fence.i flush signals of the BTB controller.
interface scr1_btb_ctrl_if;

    logic        lookup_req;
    logic [31:0] lookup_pc;
    logic        lookup_vld;
    logic        lookup_hit;
    logic [31:0] lookup_target;
    logic        upd_req;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_inv;
    logic        upd_ack;
    logic        flush_req;
    logic        busy;

    modport master (
        output lookup_req, lookup_pc, upd_req, upd_pc, upd_target, upd_inv, flush_req,
        input  lookup_vld, lookup_hit, lookup_target, upd_ack, busy
    );

    modport slave (
        input  lookup_req, lookup_pc, upd_req, upd_pc, upd_target, upd_inv, flush_req,
        output lookup_vld, lookup_hit, lookup_target, upd_ack, busy
    );

endinterface

// File: rtl/scr1_dp_ram.sv
// Simple dual-port RAM: port a writes, port b reads with one cycle latency.
// A same-address read and write in one cycle returns the old contents.
module scr1_dp_ram #(
    parameter int unsigned RAM_WIDTH = 32,
    parameter int unsigned RAM_DEPTH = 32
) (
    input  logic                         clk,
    input  logic                         wena,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dataa,
    input  logic                         renb,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    output logic [RAM_WIDTH-1:0]         qb
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wena) begin
            mem[addra] <= dataa;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (renb) begin
            qb <= mem[addrb];
        end
    end

endmodule

// File: rtl/scr1_btb_ctrl.sv
// BTB controller: invalidation sweeps, update arbitration and 1-cycle lookups.
module scr1_btb_ctrl
    import scr1_btb_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    scr1_btb_ctrl_if.slave btb
);

    type_scr1_btb_state_e state, state_nxt;
    logic [IDX_W-1:0]     sweep_ptr, sweep_ptr_nxt;
    logic                 busy_q;

    logic                 wena;
    logic [IDX_W-1:0]     waddr;
    type_scr1_btb_entry_s wdata;

    type_scr1_btb_pc_s    lkp_split, upd_split;
    logic [ENTRY_W-1:0]   ram_q;

    logic                 vld_q;
    logic                 force_miss_q;
    logic                 byp_q;
    logic [TAG_W-1:0]     tag_q;
    type_scr1_btb_entry_s byp_entry_q;
    type_scr1_btb_entry_s rd_entry;
    logic                 hit;

    logic                 unused_bits;

    assign lkp_split   = btb_pc_split(btb.lookup_pc[31:1]);
    assign upd_split   = btb_pc_split(btb.upd_pc[31:1]);
    assign unused_bits = ^{btb.lookup_pc[0], btb.upd_pc[0], btb.upd_target[0]};

    assign btb.upd_ack = btb.upd_req & (state == RUN) & ~btb.flush_req;
    assign btb.busy    = busy_q;

    // Next state and write-port mux; the sweep always owns the write port
    always_comb begin
        state_nxt     = state;
        sweep_ptr_nxt = sweep_ptr;
        wena          = 1'b0;
        waddr         = '0;
        wdata         = '0;
        case (state)
            INIT, FLUSH: begin
                // A flush during a sweep makes this cycle the first of a new sweep
                wena          = 1'b1;
                waddr         = btb.flush_req ? '0 : sweep_ptr;
                sweep_ptr_nxt = waddr + IDX_W'(1);
                if (waddr == IDX_W'(BTB_DEPTH - 1)) begin
                    state_nxt     = RUN;
                    sweep_ptr_nxt = '0;
                end
            end
            RUN: begin
                if (btb.flush_req) begin
                    state_nxt     = FLUSH;
                    sweep_ptr_nxt = '0;
                end else if (btb.upd_req) begin
                    wena         = 1'b1;
                    waddr        = upd_split.idx;
                    wdata.valid  = ~btb.upd_inv;
                    wdata.tag    = upd_split.tag;
                    wdata.target = btb.upd_target[31:1];
                end
            end
            default: begin
                state_nxt     = INIT;
                sweep_ptr_nxt = '0;
            end
        endcase
    end

    // State, sweep pointer and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= INIT;
            sweep_ptr <= '0;
            busy_q    <= 1'b1;
        end else begin
            state     <= state_nxt;
            sweep_ptr <= sweep_ptr_nxt;
            busy_q    <= (state_nxt != RUN);
        end
    end

    scr1_dp_ram #(
        .RAM_WIDTH (ENTRY_W),
        .RAM_DEPTH (BTB_DEPTH)
    ) i_ram (
        .clk   (clk),
        .wena  (wena),
        .addra (waddr),
        .dataa (wdata),
        .renb  (btb.lookup_req),
        .addrb (lkp_split.idx),
        .qb    (ram_q)
    );

    // Lookup pipeline: tag, forced-miss and same-cycle write bypass
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q        <= 1'b0;
            force_miss_q <= 1'b0;
            byp_q        <= 1'b0;
            tag_q        <= '0;
            byp_entry_q  <= '0;
        end else begin
            vld_q        <= btb.lookup_req;
            force_miss_q <= (state != RUN) | btb.flush_req;
            byp_q        <= btb.upd_ack & (upd_split.idx == lkp_split.idx);
            tag_q        <= lkp_split.tag;
            byp_entry_q  <= wdata;
        end
    end

    // Result selection: bypassed write entry wins over stale RAM data
    always_comb begin
        rd_entry = byp_q ? byp_entry_q : type_scr1_btb_entry_s'(ram_q);
        hit      = vld_q & ~force_miss_q & rd_entry.valid & (rd_entry.tag == tag_q);
    end

    assign btb.lookup_vld    = vld_q;
    assign btb.lookup_hit    = hit;
    assign btb.lookup_target = hit ? {rd_entry.target, 1'b0} : 32'h0;

endmodule

// File: tb/tb_scr1_btb_ctrl.sv
// Self-checking bench for scr1_btb_ctrl: vector table, corner sequences, random traffic.
module tb_scr1_btb_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    scr1_btb_ctrl_if btb();

    scr1_btb_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .btb   (btb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-index branch record plus remaining sweep cycles
    bit          m_valid [32];
    logic [31:0] m_pc    [32];
    logic [31:0] m_tgt   [32];
    int          sweep_left;

    // Observations from the most recent step
    logic        last_busy, last_ack, r_vld, r_hit;
    logic [31:0] r_tgt;

    typedef struct {
        bit          lreq;
        logic [31:0] lpc;
        bit          ureq;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          uinv;
        bit          e_ack;
        bit          e_vld;
        bit          e_hit;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(bit lreq, logic [31:0] lpc, bit ureq, logic [31:0] upc,
                                logic [31:0] utgt, bit uinv, bit e_ack, bit e_vld,
                                bit e_hit, logic [31:0] e_tgt);
        vec_t v;
        v.lreq = lreq; v.lpc = lpc; v.ureq = ureq; v.upc = upc; v.utgt = utgt;
        v.uinv = uinv; v.e_ack = e_ack; v.e_vld = e_vld; v.e_hit = e_hit; v.e_tgt = e_tgt;
        return v;
    endfunction

    function automatic int idx_of(logic [31:0] pc);
        return int'((pc >> 2) & 32'd31);
    endfunction

    function automatic bit same_tag(logic [31:0] a, logic [31:0] b);
        return ((a >> 7) == (b >> 7)) && (((a >> 1) & 32'd1) == ((b >> 1) & 32'd1));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit lreq, logic [31:0] lpc, bit ureq, logic [31:0] upc,
                         logic [31:0] utgt, bit uinv, bit flush);
        btb.lookup_req = lreq;
        btb.lookup_pc  = lpc;
        btb.upd_req    = ureq;
        btb.upd_pc     = upc;
        btb.upd_target = utgt;
        btb.upd_inv    = uinv;
        btb.flush_req  = flush;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        sweep_left = 32;
    endtask

    // One clock: check busy/ack before the edge, lookup result after it
    task automatic step();
        bit          running, e_ack, e_hit;
        logic [31:0] e_tgt;
        int          ix;
        #1;
        running   = (sweep_left == 0);
        last_busy = btb.busy;
        last_ack  = btb.upd_ack;
        chk("busy", 32'(btb.busy), 32'(!running));
        e_ack = btb.upd_req && running && !btb.flush_req;
        chk("upd_ack", 32'(btb.upd_ack), 32'(e_ack));
        if (e_ack) begin
            ix          = idx_of(btb.upd_pc);
            m_valid[ix] = !btb.upd_inv;
            m_pc[ix]    = btb.upd_pc;
            m_tgt[ix]   = btb.upd_target & 32'hFFFF_FFFE;
        end
        e_hit = 1'b0;
        e_tgt = 32'h0;
        if (btb.lookup_req && running && !btb.flush_req) begin
            ix = idx_of(btb.lookup_pc);
            if (m_valid[ix] && same_tag(m_pc[ix], btb.lookup_pc)) begin
                e_hit = 1'b1;
                e_tgt = m_tgt[ix];
            end
        end
        if (btb.flush_req) begin
            for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
        end
        if (running) sweep_left = btb.flush_req ? 32 : 0;
        else         sweep_left = btb.flush_req ? 31 : sweep_left - 1;
        begin
            bit e_vld;
            e_vld = btb.lookup_req;
            @(posedge clk);
            #1;
            r_vld = btb.lookup_vld;
            r_hit = btb.lookup_hit;
            r_tgt = btb.lookup_target;
            chk("lookup_vld", 32'(r_vld), 32'(e_vld));
            chk("lookup_hit", 32'(r_hit), 32'(e_hit));
            chk("lookup_target", r_tgt, e_tgt);
        end
    endtask

    // Hold reset for a cycle, check reset values, release mid-cycle
    task automatic apply_reset();
        rst_n = 1'b0;
        idle();
        model_reset();
        #1;
        chk("rst_lookup_vld", 32'(btb.lookup_vld), 32'd0);
        chk("rst_lookup_hit", 32'(btb.lookup_hit), 32'd0);
        chk("rst_lookup_target", btb.lookup_target, 32'h0);
        chk("rst_busy", 32'(btb.busy), 32'd1);
        chk("rst_upd_ack", 32'(btb.upd_ack), 32'd0);
        btb.upd_req = 1'b1;
        #1;
        chk("rst_upd_ack_req", 32'(btb.upd_ack), 32'd0);
        btb.upd_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Count busy cycles of the INIT sweep, with two early lookups
    task automatic check_init(string name);
        int cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 0)      drive(1'b1, 32'h0,   1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            else if (i == 1) drive(1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            else             idle();
            step();
            if (i < 2) begin
                chk({name, "_lkp_vld"}, 32'(r_vld), 32'd1);
                chk({name, "_lkp_hit"}, 32'(r_hit), 32'd0);
            end
            if (!last_busy) break;
            cnt++;
        end
        chk({name, "_busy_cycles"}, 32'(cnt), 32'd32);
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] hi, ix, b1;
        hi = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 : 32'h0004_2000;
        ix = 32'($urandom_range(0, 7));
        b1 = ($urandom_range(0, 3) == 0) ? 32'h2 : 32'h0;
        return hi | (ix << 2) | b1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        logic [31:0] pcs[3];

        vecs[0]  = mk(0, 32'h0,   1, 32'h104, 32'h2000, 0, 1, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'h104, 0, 32'h0,   32'h0,    0, 0, 1, 1, 32'h2000);
        vecs[2]  = mk(1, 32'h184, 0, 32'h0,   32'h0,    0, 0, 1, 0, 32'h0);
        vecs[3]  = mk(1, 32'h106, 0, 32'h0,   32'h0,    0, 0, 1, 0, 32'h0);
        vecs[4]  = mk(1, 32'h108, 1, 32'h108, 32'h3000, 0, 1, 1, 1, 32'h3000);
        vecs[5]  = mk(1, 32'h108, 1, 32'h108, 32'h3000, 1, 1, 1, 0, 32'h0);
        vecs[6]  = mk(1, 32'h108, 0, 32'h0,   32'h0,    0, 0, 1, 0, 32'h0);
        vecs[7]  = mk(0, 32'h0,   0, 32'h0,   32'h0,    0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 32'h0,   1, 32'h108, 32'h3004, 0, 1, 0, 0, 32'h0);
        vecs[9]  = mk(1, 32'h104, 1, 32'h10C, 32'h4001, 0, 1, 1, 1, 32'h2000);
        vecs[10] = mk(1, 32'h10C, 0, 32'h0,   32'h0,    0, 0, 1, 1, 32'h4000);
        vecs[11] = mk(1, 32'h108, 0, 32'h0,   32'h0,    0, 0, 1, 1, 32'h3004);

        idle();
        #2;
        apply_reset();
        check_init("init");

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].lreq, vecs[i].lpc, vecs[i].ureq, vecs[i].upc,
                  vecs[i].utgt, vecs[i].uinv, 1'b0);
            step();
            chk($sformatf("vec%0d_ack", i), 32'(last_ack), 32'(vecs[i].e_ack));
            chk($sformatf("vec%0d_vld", i), 32'(r_vld), 32'(vecs[i].e_vld));
            chk($sformatf("vec%0d_hit", i), 32'(r_hit), 32'(vecs[i].e_hit));
            chk($sformatf("vec%0d_tgt", i), r_tgt, vecs[i].e_tgt);
        end

        // Flush with a colliding update: update dropped, 32-cycle sweep
        drive(1'b0, 32'h0, 1'b1, 32'h10C, 32'h5000, 1'b0, 1'b1);
        step();
        chk("flush_upd_ack", 32'(last_ack), 32'd0);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            idle();
            step();
            if (!last_busy) break;
            cnt++;
        end
        chk("flush_busy_cycles", 32'(cnt), 32'd32);
        pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10C;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, pcs[i], 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
            step();
            chk($sformatf("post_flush%0d_vld", i), 32'(r_vld), 32'd1);
            chk($sformatf("post_flush%0d_hit", i), 32'(r_hit), 32'd0);
        end

        // Re-flush at sweep cycle 10 extends busy to 42 cycles
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, cnt == 10);
            step();
            if (!last_busy) break;
            cnt++;
        end
        chk("reflush_busy_cycles", 32'(cnt), 32'd42);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 1) == 1, rnd_pc(), $urandom_range(0, 2) != 0, rnd_pc(),
                  $urandom(), $urandom_range(0, 4) == 0, $urandom_range(0, 99) == 0);
            step();
        end

        // Reset in the middle of a flush with a lookup result pending
        idle();
        step();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        idle();
        step();
        step();
        drive(1'b1, 32'h104, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        chk("pre_rst_vld", 32'(r_vld), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(btb.lookup_vld), 32'd0);
        chk("mid_rst_busy", 32'(btb.busy), 32'd1);
        apply_reset();
        check_init("reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
